// File: rtl/stlb_arbiter.sv
// -----------------------------------------------------------------------------
// stlb_arbiter
//   Arbitrates ITLB (id 0) and DTLB (id 1) miss requests onto a shared STLB.
//   One request is in flight at a time: STLB lookup first. On a miss, or when
//   the STLB gives no answer within STLB_TMO cycles, a page walk is requested.
//   The walk result is inserted into the STLB and returned to the requester.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid[1:0], req_ready  per-requester handshake (bit0 ITLB, bit1 DTLB)
//   req_va0/1, req_pcid0/1     requester VA / PCID
//   stlb_lookup, stlb_insert   one-cycle strobes to the STLB
//   stlb_va, stlb_pcid         lookup/insert key
//   stlb_pa                    refill PA (driven while stlb_insert is high)
//   stlb_hit, stlb_miss        STLB lookup result
//   stlb_ta                    translated address, valid with stlb_hit
//   ptw_req, ptw_ready         page-walk request handshake
//   ptw_done, ptw_pa           walk completion and walked PA
//   rsp_valid[1:0], rsp_pa     one-cycle response to the granted requester
//   stat_walks                 completed page walks (wrapping)
// -----------------------------------------------------------------------------
module stlb_arbiter #(
   parameter int unsigned STLB_TMO = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  req_valid,
   input  logic [63:0] req_va0,
   input  logic [63:0] req_va1,
   input  logic [11:0] req_pcid0,
   input  logic [11:0] req_pcid1,
   output logic [1:0]  req_ready,
   output logic        stlb_lookup,
   output logic [63:0] stlb_va,
   output logic [11:0] stlb_pcid,
   input  logic        stlb_hit,
   input  logic        stlb_miss,
   input  logic [63:0] stlb_ta,
   output logic        stlb_insert,
   output logic [63:0] stlb_pa,
   output logic        ptw_req,
   input  logic        ptw_ready,
   input  logic        ptw_done,
   input  logic [63:0] ptw_pa,
   output logic [1:0]  rsp_valid,
   output logic [63:0] rsp_pa,
   output logic [31:0] stat_walks
);

   // Wait counter runs 0 .. STLB_TMO-1; the last value ends the wait.
   localparam int unsigned CntW = (STLB_TMO > 1) ? $clog2(STLB_TMO) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(STLB_TMO - 1);

   typedef enum logic [2:0] {
      StIdle, StLookup, StWaitStlb, StWalkReq, StWalkWait, StResp
   } state_e;

   state_e          state_q;
   logic            id_q;
   logic            last_q;
   logic [63:0]     va_q;
   logic [11:0]     pcid_q;
   logic [63:0]     pa_q;
   logic [CntW-1:0] cnt_q;
   logic [31:0]     walks_q;

   logic grant_any;
   logic grant_id;

   // rst_n gates the grant so req_ready stays low while reset is held even
   // though the state register already sits in StIdle.
   always_comb begin
      grant_any = rst_n && (state_q == StIdle) && (req_valid != 2'b00);
      grant_id  = (req_valid == 2'b11) ? ~last_q : req_valid[1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         id_q    <= 1'b0;
         last_q  <= 1'b1;
         va_q    <= '0;
         pcid_q  <= '0;
         pa_q    <= '0;
         cnt_q   <= '0;
         walks_q <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (grant_any) begin
                  id_q    <= grant_id;
                  last_q  <= grant_id;
                  va_q    <= grant_id ? req_va1 : req_va0;
                  pcid_q  <= grant_id ? req_pcid1 : req_pcid0;
                  state_q <= StLookup;
               end
            end
            StLookup: begin
               cnt_q   <= '0;
               state_q <= StWaitStlb;
            end
            StWaitStlb: begin
               // Hit takes priority over a simultaneous miss.
               if (stlb_hit) begin
                  pa_q    <= stlb_ta;
                  state_q <= StResp;
               end else if (stlb_miss || (cnt_q == CntLast)) begin
                  state_q <= StWalkReq;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StWalkReq: begin
               if (ptw_ready) state_q <= StWalkWait;
            end
            StWalkWait: begin
               if (ptw_done) begin
                  pa_q    <= ptw_pa;
                  walks_q <= walks_q + 32'd1;
                  state_q <= StResp;
               end
            end
            StResp:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   always_comb begin
      req_ready   = grant_any ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
      stlb_lookup = (state_q == StLookup);
      stlb_insert = (state_q == StWalkWait) && ptw_done;
      stlb_va     = va_q;
      stlb_pcid   = pcid_q;
      stlb_pa     = stlb_insert ? ptw_pa : 64'd0;
      ptw_req     = (state_q == StWalkReq);
      rsp_valid   = (state_q == StResp) ? (id_q ? 2'b10 : 2'b01) : 2'b00;
      rsp_pa      = pa_q;
      stat_walks  = walks_q;
   end

endmodule

// File: tb/tb_stlb_arbiter.sv
module tb_stlb_arbiter;
   localparam int unsigned STLB_TMO = 15;

   typedef enum int {KHit, KMiss, KTmo, KBoth} kind_e;

   typedef struct {
      logic [1:0]  req;
      logic [63:0] va0;
      logic [63:0] va1;
      logic [11:0] pcid0;
      logic [11:0] pcid1;
      kind_e       kind;
      int          dly;
      logic [63:0] data;
      logic        exp_id;
      bit          hold;
   } vec_t;

   typedef struct {
      logic [1:0]  onehot;
      logic [63:0] pa;
      int          lat;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [63:0] req_va0, req_va1;
   logic [11:0] req_pcid0, req_pcid1;
   logic [1:0]  req_ready;
   logic        stlb_lookup;
   logic [63:0] stlb_va;
   logic [11:0] stlb_pcid;
   logic        stlb_hit, stlb_miss;
   logic [63:0] stlb_ta;
   logic        stlb_insert;
   logic [63:0] stlb_pa;
   logic        ptw_req, ptw_ready, ptw_done;
   logic [63:0] ptw_pa;
   logic [1:0]  rsp_valid;
   logic [63:0] rsp_pa;
   logic [31:0] stat_walks;

   int   n_chk = 0;
   int   errs = 0;
   int   cyc = 0;
   int   grant_cyc = 0;
   int   exp_walks = 0;
   exp_t sb[$];
   vec_t vecs[10];

   stlb_arbiter #(.STLB_TMO(STLB_TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_va0(req_va0), .req_va1(req_va1),
      .req_pcid0(req_pcid0), .req_pcid1(req_pcid1), .req_ready(req_ready),
      .stlb_lookup(stlb_lookup), .stlb_va(stlb_va), .stlb_pcid(stlb_pcid),
      .stlb_hit(stlb_hit), .stlb_miss(stlb_miss), .stlb_ta(stlb_ta),
      .stlb_insert(stlb_insert), .stlb_pa(stlb_pa),
      .ptw_req(ptw_req), .ptw_ready(ptw_ready), .ptw_done(ptw_done), .ptw_pa(ptw_pa),
      .rsp_valid(rsp_valid), .rsp_pa(rsp_pa), .stat_walks(stat_walks)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Response scoreboard and strobe exclusivity monitor.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if ((int'(stlb_lookup) + int'(stlb_insert) + int'(ptw_req)) > 1) begin
            errs++;
            $display("FAIL strobe_excl: got lookup=%b insert=%b ptw_req=%b required at most one",
                     stlb_lookup, stlb_insert, ptw_req);
         end
         if (rsp_valid != 2'b00) begin
            n_chk++;
            if (sb.size() == 0) begin
               errs++;
               $display("FAIL rsp_unexpected: got rsp_valid=%b rsp_pa=%0h required none",
                        rsp_valid, rsp_pa);
            end else begin
               e = sb.pop_front();
               if (rsp_valid !== e.onehot || rsp_pa !== e.pa ||
                   (e.lat != 0 && (cyc - grant_cyc) != e.lat)) begin
                  errs++;
                  $display("FAIL rsp: got valid=%b pa=%0h lat=%0d required valid=%b pa=%0h lat=%0d",
                           rsp_valid, rsp_pa, cyc - grant_cyc, e.onehot, e.pa, e.lat);
               end
            end
         end
      end
   end

   // Walk handshake: ptw_ready after 2 cycles of ptw_req, done 1 cycle later.
   task automatic walk(input logic [63:0] pa, input logic [63:0] va);
      @(negedge clk);
      chk("ptw_req_on", ptw_req, 1);
      tick();
      ptw_ready = 1'b1;
      tick();
      ptw_ready = 1'b0;
      @(negedge clk);
      chk("ptw_req_released", ptw_req, 0);
      tick();
      ptw_pa   = pa;
      ptw_done = 1'b1;
      @(negedge clk);
      chk("insert", stlb_insert, 1);
      chk("insert_pa", stlb_pa, pa);
      chk("insert_va", stlb_va, va);
      tick();
      ptw_done = 1'b0;
      exp_walks++;
      chk("stat_walks", stat_walks, 64'(exp_walks));
   endtask

   task automatic run_vec(input vec_t v);
      exp_t        e;
      bit          got;
      logic [63:0] va;
      req_valid = v.req;
      req_va0   = v.va0;
      req_va1   = v.va1;
      req_pcid0 = v.pcid0;
      req_pcid1 = v.pcid1;
      va        = v.exp_id ? v.va1 : v.va0;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         if (req_ready != 2'b00) got = 1'b1;
      end
      chk("grant", req_ready, v.exp_id ? 2'b10 : 2'b01);
      if (!got) return;
      grant_cyc = cyc;
      e.onehot  = v.exp_id ? 2'b10 : 2'b01;
      e.pa      = v.data;
      e.lat     = (v.kind == KHit || v.kind == KBoth) ? 3 + v.dly : 0;
      sb.push_back(e);
      tick();
      if (!v.hold) req_valid = 2'b00;
      @(negedge clk);
      chk("lookup", stlb_lookup, 1);
      chk("lookup_va", stlb_va, va);
      chk("lookup_pcid", stlb_pcid, v.exp_id ? v.pcid1 : v.pcid0);
      tick();
      case (v.kind)
         KHit, KBoth: begin
            repeat (v.dly) tick();
            stlb_hit  = 1'b1;
            stlb_miss = (v.kind == KBoth);
            stlb_ta   = v.data;
            tick();
            stlb_hit  = 1'b0;
            stlb_miss = 1'b0;
            @(negedge clk);
            chk("hit_no_walk", ptw_req, 0);
         end
         KMiss: begin
            stlb_miss = 1'b1;
            tick();
            stlb_miss = 1'b0;
            walk(v.data, va);
         end
         default: begin
            for (int i = 0; i < int'(STLB_TMO); i++) begin
               @(negedge clk);
               chk("tmo_quiet", ptw_req, 0);
               tick();
            end
            walk(v.data, va);
         end
      endcase
      tick();
      for (int i = 0; i < 5 && sb.size() != 0; i++) tick();
      chk("rsp_seen", 64'(sb.size()), 0);
   endtask

   initial begin
      vecs[0] = '{2'b11, 64'h1111_0000, 64'h2222_0000, 12'h001, 12'h002, KHit, 0, 64'hA1000, 1'b0, 1'b1};
      vecs[1] = '{2'b11, 64'h1111_0000, 64'h2222_0000, 12'h001, 12'h002, KHit, 0, 64'hA2000, 1'b1, 1'b1};
      vecs[2] = '{2'b11, 64'h1111_0000, 64'h2222_0000, 12'h001, 12'h002, KHit, 0, 64'hA3000, 1'b0, 1'b1};
      vecs[3] = '{2'b11, 64'h1111_0000, 64'h2222_0000, 12'h001, 12'h002, KHit, 1, 64'hA4000, 1'b1, 1'b0};
      vecs[4] = '{2'b01, 64'h1000, 64'h0, 12'h005, 12'h000, KHit, 0, 64'hA000, 1'b0, 1'b0};
      vecs[5] = '{2'b10, 64'h0, 64'hFFFF_8000_7000_2000, 12'h000, 12'hABC, KMiss, 0, 64'hBEEF000,
                  1'b1, 1'b0};
      vecs[6] = '{2'b01, 64'h0000_7FFF_1234_5000, 64'h0, 12'hFFF, 12'h000, KTmo, 0, 64'h5555_0000,
                  1'b0, 1'b0};
      vecs[7] = '{2'b11, 64'h3000, 64'h4000, 12'h033, 12'h044, KBoth, 2, 64'hC0DE000, 1'b1, 1'b0};
      vecs[8] = '{2'b11, 64'h5000, 64'h6000, 12'h055, 12'h066, KHit, 14, 64'hD00D000, 1'b0, 1'b0};
      vecs[9] = '{2'b10, 64'h0, 64'h9000, 12'h000, 12'h099, KMiss, 0, 64'hF00F000, 1'b1, 1'b0};

      rst_n = 1'b0;
      req_valid = 2'b11;
      req_va0 = 64'h1; req_va1 = 64'h2; req_pcid0 = '0; req_pcid1 = '0;
      stlb_hit = 0; stlb_miss = 0; stlb_ta = '0;
      ptw_ready = 0; ptw_done = 1'b1; ptw_pa = 64'h77;
      #3;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_insert", stlb_insert, 0);
      chk("rst_stlb_pa", stlb_pa, 0);
      chk("rst_ptw_req", ptw_req, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_stat", stat_walks, 0);
      repeat (2) tick();
      req_valid = 2'b00;
      ptw_done  = 1'b0;
      rst_n     = 1'b1;
      tick();

      for (int i = 0; i < 10; i++) run_vec(vecs[i]);

      // Stray results while idle must be ignored.
      stlb_hit = 1'b1; stlb_miss = 1'b1; ptw_done = 1'b1; ptw_pa = 64'h1234;
      @(negedge clk);
      chk("idle_insert", stlb_insert, 0);
      tick();
      stlb_hit = 1'b0; stlb_miss = 1'b0; ptw_done = 1'b0;
      @(negedge clk);
      chk("idle_stat", stat_walks, 64'(exp_walks));
      tick();

      // Reset in WALK_WAIT drops the transaction.
      req_valid = 2'b10; req_va1 = 64'hABCD_0000; req_pcid1 = 12'h321;
      @(negedge clk);
      chk("rw_grant", req_ready, 2'b10);
      tick();
      req_valid = 2'b00;
      tick();
      stlb_miss = 1'b1;
      tick();
      stlb_miss = 1'b0;
      ptw_ready = 1'b1;
      tick();
      ptw_ready = 1'b0;
      #2;
      req_valid = 2'b01;
      rst_n = 1'b0;
      exp_walks = 0;
      sb.delete();
      #1;
      chk("rw_req_ready", req_ready, 0);
      chk("rw_lookup", stlb_lookup, 0);
      chk("rw_va", stlb_va, 0);
      chk("rw_pcid", stlb_pcid, 0);
      chk("rw_rsp_pa", rsp_pa, 0);
      chk("rw_stat", stat_walks, 0);
      tick();
      req_valid = 2'b00;
      rst_n = 1'b1;
      ptw_done = 1'b1; ptw_pa = 64'hDEAD000;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rw_no_insert", stlb_insert, 0);
         tick();
      end
      ptw_done = 1'b0;
      chk("rw_stat_after", stat_walks, 0);

      // RR pointer back to 1 and first grant right after reset release.
      rst_n = 1'b0;
      tick();
      req_valid = 2'b11;
      rst_n = 1'b1;
      run_vec('{2'b11, 64'hE000, 64'hF000, 12'h0E0, 12'h0F0, KHit, 0, 64'hE1000, 1'b0, 1'b0});

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, errs);
      $finish;
   end
endmodule
